rom_fetch_ctrl: RTL and testbench

Sequences instruction fetch from the combinational instruction ROM (`reg_rom`, 32-bit byte address in, 32-bit word out) for the single-cycle RISC-V core. It:
- owns the program counter and drives the ROM address;
- registers each fetched word together with its PC;
- honours stall and branch/jump redirect requests from the core;
- stops on a halt instruction or on an illegal fetch address.

It sits between `reg_rom` and the core's decode stage.

---
 rtl/rom_fetch_ctrl.sv | 98 +++++++++
 tb/tb_rom_fetch_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_ctrl.sv
// rtl/rom_fetch_ctrl.sv - instruction fetch sequencer for a combinational ROM
// Owns the PC, registers each fetched word with its PC, handles stall/redirect/halt/fault.
module rom_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ROM_BYTES  = 128,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rd,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT, S_FAULT} state_t;

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);

  state_t      state;
  logic [31:0] pc;

  assign rom_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      instr         <= 32'h0;
      instr_pc      <= 32'h0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
      fault         <= 1'b0;
      retired_count <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          instr_valid <= 1'b0;
          if (start) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
          end
        end
        S_FETCH: begin
          // Redirect outranks both the range check and stall, so a taken branch
          // squashes whatever word (including a halt) sits at the old PC.
          if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            instr_valid <= 1'b0;
          end else if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
          end else if (pc >= ROM_LIMIT) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instr       <= rom_rd;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (retired_count != 32'hFFFF_FFFF)
              retired_count <= retired_count + 32'd1;
            if (rom_rd == HALT_INSTR) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        S_HALT: begin
          instr_valid <= 1'b0;
          if (start) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            halted <= 1'b0;
          end
        end
        S_FAULT: begin
          instr_valid <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb/tb_rom_fetch_ctrl.sv - self-checking bench for rom_fetch_ctrl
module tb_rom_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] rom_addr;
  logic [31:0] rom_rd;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic        fault;
  logic [31:0] retired_count;

  logic [31:0] rom [32];

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rp;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ecnt;
  } step_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  rom_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .halted(halted), .fault(fault),
    .retired_count(retired_count)
  );

  assign rom_rd = (rom_addr < 32'd128) ? rom[rom_addr[6:2]] : 32'h0;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_instr valid=%b instr=%h pc=%h, expected 0/0/0", instr_valid, instr, instr_pc);
    end
    checks++;
    if (halted !== 1'b0 || fault !== 1'b0 || retired_count !== 32'h0 || rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_status halted=%b fault=%b cnt=%0d addr=%h, expected 0/0/0/0",
               halted, fault, retired_count, rom_addr);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (instr_valid !== 1'b0 || retired_count !== 32'h0 || rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL idle_hold valid=%b cnt=%0d addr=%h, expected 0/0/0", instr_valid, retired_count, rom_addr);
    end
  endtask

  task automatic test_straight_line();
    exp_t e;
    int   cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) sb.push_back('{1'b1, 32'(k * 4), 32'(k + 1)});
    cyc = 0;
    while (sb.size() > 0 && cyc < 40) begin
      tick();
      cyc++;
      if (instr_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (instr_pc !== e.pc || instr !== rom[e.pc[6:2]] || retired_count !== e.cnt) begin
          errors++;
          $display("FAIL straight pc=%h instr=%h cnt=%0d, expected pc=%h instr=%h cnt=%0d",
                   instr_pc, instr, retired_count, e.pc, rom[e.pc[6:2]], e.cnt);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || cyc != 32) begin
      errors++;
      $display("FAIL straight_cycles cycles=%0d left=%0d, expected cycles=32 left=0", cyc, sb.size());
      sb.delete();
    end
    tick();
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || retired_count !== 32'd32 || fault !== 1'b0) begin
      errors++;
      $display("FAIL halt_state halted=%b valid=%b cnt=%0d fault=%b, expected 1/0/32/0",
               halted, instr_valid, retired_count, fault);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b1 || fault !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_ignores_redirect halted=%b fault=%b valid=%b, expected 1/0/0", halted, fault, instr_valid);
    end
  endtask

  task automatic test_restart();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (halted !== 1'b0 || instr_valid !== 1'b0 || rom_addr !== 32'h0 || retired_count !== 32'd32) begin
      errors++;
      $display("FAIL restart halted=%b valid=%b addr=%h cnt=%0d, expected 0/0/0/32",
               halted, instr_valid, rom_addr, retired_count);
    end
  endtask

  task automatic test_stall();
    step_t s[7];
    exp_t  e;
    s = '{
      '{1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 32'd33},
      '{1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 32'd34},
      '{1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 32'd35},
      '{1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 32'd35},
      '{1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 32'd35},
      '{1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 32'd35},
      '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 32'd36}
    };
    foreach (s[i]) begin
      sb.push_back('{s[i].ev, s[i].epc, s[i].ecnt});
      stall = s[i].st;
      redirect_valid = s[i].rv;
      redirect_pc = s[i].rp;
      tick();
      e = sb.pop_front();
      checks++;
      if (instr_valid !== e.v || retired_count !== e.cnt ||
          (e.v && (instr_pc !== e.pc || instr !== rom[e.pc[6:2]]))) begin
        errors++;
        $display("FAIL stall[%0d] valid=%b pc=%h instr=%h cnt=%0d, expected valid=%b pc=%h instr=%h cnt=%0d",
                 i, instr_valid, instr_pc, instr, retired_count, e.v, e.pc, rom[e.pc[6:2]], e.cnt);
      end
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect();
    step_t s[9];
    exp_t  e;
    // Last three rows: redirect onto the halt word, then redirect away while it is fetched.
    s = '{
      '{1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 32'd36},
      '{1'b0, 1'b0, 32'h00, 1'b1, 32'h40, 32'd37},
      '{1'b0, 1'b0, 32'h00, 1'b1, 32'h44, 32'd38},
      '{1'b1, 1'b1, 32'h20, 1'b0, 32'h00, 32'd38},
      '{1'b0, 1'b0, 32'h00, 1'b1, 32'h20, 32'd39},
      '{1'b0, 1'b1, 32'h10, 1'b0, 32'h00, 32'd39},
      '{1'b0, 1'b1, 32'h7C, 1'b0, 32'h00, 32'd39},
      '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00, 32'd39},
      '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 32'd40}
    };
    foreach (s[i]) begin
      sb.push_back('{s[i].ev, s[i].epc, s[i].ecnt});
      stall = s[i].st;
      redirect_valid = s[i].rv;
      redirect_pc = s[i].rp;
      tick();
      e = sb.pop_front();
      checks++;
      if (instr_valid !== e.v || retired_count !== e.cnt ||
          (e.v && (instr_pc !== e.pc || instr !== rom[e.pc[6:2]]))) begin
        errors++;
        $display("FAIL redirect[%0d] valid=%b pc=%h instr=%h cnt=%0d, expected valid=%b pc=%h instr=%h cnt=%0d",
                 i, instr_valid, instr_pc, instr, retired_count, e.v, e.pc, rom[e.pc[6:2]], e.cnt);
      end
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL halt_squashed halted=%b fault=%b, expected 0/0", halted, fault);
    end
  endtask

  task automatic test_out_of_range();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || fault !== 1'b0 || rom_addr !== 32'h80) begin
      errors++;
      $display("FAIL oor_bubble valid=%b fault=%b addr=%h, expected 0/0/80", instr_valid, fault, rom_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0 || fault !== 1'b1 || retired_count !== 32'd40) begin
      errors++;
      $display("FAIL oor_fault valid=%b fault=%b cnt=%0d, expected 0/1/40", instr_valid, fault, retired_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (fault !== 1'b1 || instr_valid !== 1'b0 || retired_count !== 32'd40 || halted !== 1'b0) begin
      errors++;
      $display("FAIL oor_sticky fault=%b valid=%b cnt=%0d halted=%b, expected 1/0/40/0",
               fault, instr_valid, retired_count, halted);
    end
  endtask

  task automatic test_misaligned();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || retired_count !== 32'd1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL mis_setup valid=%b pc=%h cnt=%0d fault=%b, expected 1/0/1/0",
               instr_valid, instr_pc, retired_count, fault);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== 32'h4 || retired_count !== 32'd1) begin
      errors++;
      $display("FAIL mis_fault fault=%b valid=%b addr=%h cnt=%0d, expected 1/0/4/1",
               fault, instr_valid, rom_addr, retired_count);
    end
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
    end
    checks++;
    if (fault !== 1'b1 || instr_valid !== 1'b0 || retired_count !== 32'd1) begin
      errors++;
      $display("FAIL mis_sticky fault=%b valid=%b cnt=%0d, expected 1/0/1", fault, instr_valid, retired_count);
    end
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || retired_count !== 32'h0 ||
        fault !== 1'b0 || halted !== 1'b0 || rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset valid=%b instr=%h pc=%h cnt=%0d fault=%b halted=%b addr=%h, expected all 0",
               instr_valid, instr, instr_pc, retired_count, fault, halted, rom_addr);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (instr_valid !== 1'b0 || retired_count !== 32'h0 || rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_idle valid=%b cnt=%0d addr=%h, expected 0/0/0", instr_valid, retired_count, rom_addr);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== rom[0] || retired_count !== 32'd1) begin
      errors++;
      $display("FAIL post_reset_start valid=%b pc=%h instr=%h cnt=%0d, expected 1/0/%h/1",
               instr_valid, instr_pc, instr, retired_count, rom[0]);
    end
  endtask

  initial begin
    for (int k = 0; k < 31; k++) rom[k] = 32'h0000_0013 + (32'(k) << 20);
    rom[31] = 32'h0000_0073;
    test_reset();
    test_straight_line();
    test_restart();
    test_stall();
    test_redirect();
    test_out_of_range();
    test_misaligned();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
